// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and clear-on-reset sequencer for a 64x8 single-port RAM.
// Define RAM_ARB_STATS_EN to add saturating per-requester grant counters.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
`ifdef RAM_ARB_STATS_EN
  output logic [15:0]       o_a_grant_cnt,
  output logic [15:0]       o_b_grant_cnt,
`endif
  output logic              o_init_done
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_q;
  state_t state_d;

  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_d;

  logic init_done_d;
  logic prio_b_q;
  logic prio_b_d;

  logic gnt_a;
  logic gnt_b;
  logic acc_a;
  logic acc_b;
  logic acc;
  cmd_t sel;

  logic              ram_ce_d;
  logic              ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;

  // Stage 1 lines up with the command on the RAM bus,
  // stage 2 with the RAM read data; tag 1 means B.
  logic s1_rd_q;
  logic s1_tag_q;
  logic s2_rd_q;
  logic s2_tag_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == RUN) begin
      unique case (1'b1)
        (i_a_valid && !i_b_valid): gnt_a = 1'b1;
        (!i_a_valid && i_b_valid): gnt_b = 1'b1;
        (i_a_valid && i_b_valid): begin
          if (prio_b_q) gnt_b = 1'b1;
          else          gnt_a = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_a_ready = gnt_a;
  assign o_b_ready = gnt_b;
  assign acc_a     = gnt_a & i_a_valid;
  assign acc_b     = gnt_b & i_b_valid;
  assign acc       = acc_a | acc_b;

  always_comb begin
    sel = '{we: i_a_we, addr: i_a_addr, wdata: i_a_wdata};
    if (acc_b) begin
      sel = '{we: i_b_we, addr: i_b_addr, wdata: i_b_wdata};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = o_init_done;
    prio_b_d    = prio_b_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = o_ram_we;
    ram_addr_d  = o_ram_addr;
    ram_wdata_d = o_ram_wdata;
    unique case (state_q)
      INIT: begin
        // The extra counter bit marks "last address already issued".
        if (cnt_q[ADDR_W]) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          ram_ce_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = cnt_q[ADDR_W-1:0];
          ram_wdata_d = INIT_VAL;
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (acc) begin
          ram_ce_d    = 1'b1;
          ram_we_d    = sel.we;
          ram_addr_d  = sel.addr;
          ram_wdata_d = sel.wdata;
          prio_b_d    = acc_a;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      o_init_done <= 1'b0;
      prio_b_q    <= 1'b0;
      o_ram_ce    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_init_done <= init_done_d;
      prio_b_q    <= prio_b_d;
      o_ram_ce    <= ram_ce_d;
      o_ram_we    <= ram_we_d;
      o_ram_addr  <= ram_addr_d;
      o_ram_wdata <= ram_wdata_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_rd_q    <= 1'b0;
      s1_tag_q   <= 1'b0;
      s2_rd_q    <= 1'b0;
      s2_tag_q   <= 1'b0;
      o_a_rvalid <= 1'b0;
      o_b_rvalid <= 1'b0;
      o_a_rdata  <= '0;
      o_b_rdata  <= '0;
    end else begin
      s1_rd_q    <= acc & ~sel.we;
      s1_tag_q   <= acc_b;
      s2_rd_q    <= s1_rd_q;
      s2_tag_q   <= s1_tag_q;
      o_a_rvalid <= s2_rd_q & ~s2_tag_q;
      o_b_rvalid <= s2_rd_q & s2_tag_q;
      if (s2_rd_q && !s2_tag_q) o_a_rdata <= i_ram_rdata;
      if (s2_rd_q && s2_tag_q)  o_b_rdata <= i_ram_rdata;
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a_grant_cnt <= '0;
      o_b_grant_cnt <= '0;
    end else begin
      if (acc_a && o_a_grant_cnt != 16'hFFFF) begin
        o_a_grant_cnt <= o_a_grant_cnt + 16'd1;
      end
      if (acc_b && o_b_grant_cnt != 16'hFFFF) begin
        o_b_grant_cnt <= o_b_grant_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x8 single-port RAM.
// Grant counter checks compile in when RAM_ARB_STATS_EN is defined.
module tb_ram_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic          a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic          b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          init_done;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   a_cnt;
  logic [15:0]   b_cnt;
`endif

  int n_assert = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  ram_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_we      (a_we),
    .i_a_addr    (a_addr),
    .i_a_wdata   (a_wdata),
    .o_a_rvalid  (a_rvalid),
    .o_a_rdata   (a_rdata),
    .i_b_valid   (b_valid),
    .o_b_ready   (b_ready),
    .i_b_we      (b_we),
    .i_b_addr    (b_addr),
    .i_b_wdata   (b_wdata),
    .o_b_rvalid  (b_rvalid),
    .o_b_rdata   (b_rdata),
    .o_ram_ce    (ram_ce),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
`ifdef RAM_ARB_STATS_EN
    .o_a_grant_cnt (a_cnt),
    .o_b_grant_cnt (b_cnt),
`endif
    .o_init_done (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    a_valid = 1'b1;
    a_we    = 1'b0;
    a_addr  = 6'h2A;
    b_valid = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_ce", ram_ce, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_done", init_done, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    b_valid = 1'b0;
    rst_n   = 1'b1;

    // Clear sweep with A already requesting
    for (int i = 0; i < 64; i++) begin
      tick();
      #1;
      chk("init_ce", ram_ce, 1);
      chk("init_we", ram_we, 1);
      chk("init_addr", ram_addr, i);
      chk("init_wdata", ram_wdata, 0);
      chk("init_ready", a_ready, 0);
      chk("init_done_lo", init_done, 0);
    end
    tick();
    #1;
    chk("done_hi", init_done, 1);
    chk("done_ce", ram_ce, 0);
    chk("first_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    #1;
    chk("rd2a_ce", ram_ce, 1);
    chk("rd2a_we", ram_we, 0);
    chk("rd2a_addr", ram_addr, 6'h2A);
    chk("rd2a_rv_t1", a_rvalid, 0);
    tick();
    #1;
    chk("rd2a_rv_t2", a_rvalid, 0);
    tick();
    #1;
    chk("rd2a_rv_t3", a_rvalid, 1);
    chk("rd2a_data", a_rdata, 0);
    tick();
    #1;
    chk("rd2a_rv_t4", a_rvalid, 0);

    // Back-to-back writes then reads from A
    for (int k = 0; k < 132; k++) begin
      tick();
      if (k < 64) begin
        a_valid = 1'b1;
        a_we    = 1'b1;
        a_addr  = AW'(k);
        a_wdata = DW'(k + 1);
      end else if (k < 128) begin
        a_valid = 1'b1;
        a_we    = 1'b0;
        a_addr  = AW'(k - 64);
      end else begin
        a_valid = 1'b0;
      end
      #1;
      if (k < 128) chk("bb_ready", a_ready, 1);
      chk("bb_rvalid", a_rvalid, (k >= 67 && k < 131));
      if (k >= 67 && k < 131) chk("bb_rdata", a_rdata, k - 66);
      if (k == 131) chk("bb_hold", a_rdata, 64);
      chk("bb_b_rvalid", b_rvalid, 0);
    end

    // Read-after-write across requesters
    tick();
    a_valid = 1'b1;
    a_we    = 1'b1;
    a_addr  = 6'h3F;
    a_wdata = 8'hC3;
    #1;
    chk("raw_a_ready", a_ready, 1);
    chk("raw_b_ready0", b_ready, 0);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_we    = 1'b0;
    b_addr  = 6'h3F;
    #1;
    chk("raw_b_ready", b_ready, 1);
    chk("raw_a_ready0", a_ready, 0);
    tick();
    b_valid = 1'b0;
    #1;
    chk("raw_rv_t2", b_rvalid, 0);
    tick();
    #1;
    chk("raw_rv_t3", b_rvalid, 0);
    tick();
    #1;
    chk("raw_rv_t4", b_rvalid, 1);
    chk("raw_data", b_rdata, 8'hC3);
    chk("raw_a_rv", a_rvalid, 0);
    tick();
    #1;
    chk("raw_rv_t5", b_rvalid, 0);

    // Both requesters contending
    for (int c = 0; c < 12; c++) begin
      tick();
      a_valid = (c < 8);
      a_we    = 1'b0;
      a_addr  = 6'd5;
      b_valid = (c < 8);
      b_we    = 1'b0;
      b_addr  = 6'd9;
      #1;
      if (c < 8) begin
        chk("rr_a_ready", a_ready, (c % 2 == 0));
        chk("rr_b_ready", b_ready, (c % 2 == 1));
      end
      chk("rr_both", a_ready & b_ready, 0);
      if (c >= 3) begin
        chk("rr_a_rv", a_rvalid, (c <= 10 && (c - 3) % 2 == 0));
        chk("rr_b_rv", b_rvalid, (c <= 10 && (c - 3) % 2 == 1));
        if (c <= 10 && (c - 3) % 2 == 0) chk("rr_a_data", a_rdata, 8'h06);
        if (c <= 10 && (c - 3) % 2 == 1) chk("rr_b_data", b_rdata, 8'h0A);
      end
      if (c == 4) chk("rr_a_hold", a_rdata, 8'h06);
    end

    // Reset with two reads in flight
    tick();
    a_valid = 1'b1;
    a_we    = 1'b0;
    a_addr  = 6'd1;
    #1;
    chk("mr_ready0", a_ready, 1);
    tick();
    a_addr = 6'd2;
    #1;
    chk("mr_ready1", a_ready, 1);
    tick();
    a_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mr_done_lo", init_done, 0);
    chk("mr_ce", ram_ce, 0);
    chk("mr_rv0", a_rvalid, 0);
    chk("mr_rdata", a_rdata, 0);
    repeat (3) begin
      tick();
      #1;
      chk("mr_a_rv", a_rvalid, 0);
      chk("mr_b_rv", b_rvalid, 0);
    end
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_rel_ce", ram_ce, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("mr_sweep_ce", ram_ce, 1);
      chk("mr_sweep_addr", ram_addr, i);
      chk("mr_sweep_rv", a_rvalid, 0);
    end
    n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    chk("mr_sweep_done", init_done, 1);

`ifdef RAM_ARB_STATS_EN
    #1;
    chk("st_a_zero", a_cnt, 0);
    chk("st_b_zero", b_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      a_valid = 1'b1;
      a_we    = 1'b1;
      a_addr  = AW'(i);
      a_wdata = '0;
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      a_valid = 1'b0;
      b_valid = 1'b1;
      b_we    = 1'b1;
      b_addr  = AW'(i);
      b_wdata = '0;
    end
    tick();
    b_valid = 1'b0;
    tick();
    #1;
    chk("st_a_cnt", a_cnt, 10);
    chk("st_b_cnt", b_cnt, 7);
    a_valid = 1'b1;
    a_we    = 1'b0;
    for (int i = 0; i < 69990; i++) tick();
    a_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("st_a_sat", a_cnt, 16'hFFFF);
    chk("st_b_keep", b_cnt, 7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 64x8 single-port singleRAM (ports i_clk, i_ce, i_we, i_addr, i_data, o_data).
- After reset it clears every RAM word to INIT_VAL, then shares the RAM between requester A and requester B.
- Each requester uses a valid/ready command handshake and receives a registered read response.
- Sits between the two client blocks and the singleRAM instance; it is the only driver of the RAM ports.

Parameters:
ADDR_W, 6, RAM address width; depth = 2**ADDR_W words
DATA_W, 8, RAM data width
INIT_VAL, 0, value written to every word during the post-reset clear sweep

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_a_valid  in  1  requester A command valid
o_a_ready  out  1  requester A command accepted this cycle
i_a_we  in  1  A command type: 1 = write, 0 = read
i_a_addr  in  ADDR_W  A address
i_a_wdata  in  DATA_W  A write data
o_a_rvalid  out  1  A read response valid (one-cycle pulse)
o_a_rdata  out  DATA_W  A read data
i_b_valid / o_b_ready / i_b_we / i_b_addr / i_b_wdata / o_b_rvalid / o_b_rdata  same widths and meaning as A
o_ram_ce  out  1  to RAM i_ce
o_ram_we  out  1  to RAM i_we
o_ram_addr  out  ADDR_W  to RAM i_addr
o_ram_wdata  out  DATA_W  to RAM i_data
i_ram_rdata  in  DATA_W  from RAM o_data
o_init_done  out  1  clear sweep finished; arbitration enabled

Behaviour:
- Reset (asynchronous, i_rst_n=0): all outputs 0; state=INIT; sweep counter=0; round-robin pointer favours A; response pipeline flushed.
- RAM timing contract: the RAM samples ce/we/addr/data on a rising edge. A read returns o_data one cycle later.
- INIT state:
  - Each cycle: ce=1, we=1, addr=counter, wdata=INIT_VAL.
  - Counter increments 0..DEPTH-1, taking DEPTH cycles.
  - o_a_ready and o_b_ready are held 0 regardless of valid.
  - After address DEPTH-1 is issued: state -> RUN and o_init_done=1 on the next cycle, then held.
- RUN state, grant (combinational):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not granted last. The pointer updates only on an accepted handshake.
  - o_x_ready = grant to x. At most one ready is high per cycle; ready never asserts without the matching valid.
- Accept at cycle T (valid & ready):
  - The command is registered into o_ram_* at T+1 with ce=1.
  - No accept at T: o_ram_ce=0 at T+1; addr/wdata hold their previous values.
- Read accepted at T:
  - RAM samples at the end of T+1; i_ram_rdata is valid in T+2 and is registered.
  - o_x_rvalid=1 and o_x_rdata valid in T+3, for exactly one cycle, to the originating requester only.
  - Accept-to-response latency is 3 cycles.
- Write accepted: no response pulse.
- Throughput: one command per cycle, sustained. Up to 2 reads can be in flight; a requester tag travels with each pipeline stage.
- Ordering: responses return in acceptance order.
- Read-after-write: a read of an address accepted the cycle after a write to that address returns the new data, because the write reaches the RAM first.
- No response back-pressure: a requester must always take rvalid.
- o_x_rdata holds its last value when rvalid=0.
- Reset mid-operation: in-flight responses are dropped (no rvalid). INIT restarts from address 0 and o_init_done falls immediately.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined: adds outputs o_a_grant_cnt [15:0] and o_b_grant_cnt [15:0].
  - Each counts accepted handshakes for its requester in RUN and saturates at 0xFFFF.
  - Both reset to 0 and are not incremented by INIT writes.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Release reset -> exactly 64 cycles with o_ram_ce=1, we=1, addr 0..63, wdata=0x00; ready low throughout; o_init_done rises after addr 63; A read of addr 0x2A afterwards -> o_a_rdata=0x00 three cycles after accept.
- A writes addr i, data i+1 for i=0..63 back-to-back, then reads 0..63 -> one accept per cycle; o_a_rvalid pulses 64 times with rdata=i+1 in order, latency 3.
- A and B both valid continuously, A reads addr 5, B reads addr 9 (preloaded 0x06/0x0A) -> grants alternate A,B,A,B; each requester receives only its own data; no cycle with both readies high.
- A writes 0x3F=0xC3 at T and B reads 0x3F at T+1 -> B receives 0xC3 at T+4.
- Assert i_rst_n=0 with two reads in flight -> no rvalid appears; o_init_done=0; INIT sweep restarts at addr 0 after release.
- With RAM_ARB_STATS_EN: 10 A accepts and 7 B accepts -> o_a_grant_cnt=10, o_b_grant_cnt=7; after 70000 A accepts -> o_a_grant_cnt holds 0xFFFF.
